// File: rtl/lfsr_gen.sv
// Parametrised Fibonacci LFSR with seed load, step mode, advance counter, wrap and zero-lock guard.
// Optional two-digit hex 7-segment output enabled by defining LFSR_SEG_EN.
module lfsr_gen #(
    parameter int unsigned          WIDTH      = 8,
    parameter logic [WIDTH-1:0]     TAPS       = 8'h1D,
    parameter logic [WIDTH-1:0]     RESET_SEED = 8'h01
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] seed,
    input  logic             step_mode,
    input  logic             step,
    output logic [WIDTH-1:0] state,
    output logic             bit_out,
    output logic [WIDTH-1:0] cnt,
    output logic             wrap,
    output logic             lockup
`ifdef LFSR_SEG_EN
    ,
    output logic [15:0]      seg
`endif
);

    logic [WIDTH-1:0] start;
    logic             step_q;

    logic             fill;
    logic [WIDTH-1:0] next_state;
    logic             step_rise;
    logic             adv;
    logic [WIDTH-1:0] load_val;

    logic [WIDTH-1:0] state_d;
    logic [WIDTH-1:0] start_d;
    logic [WIDTH-1:0] cnt_d;
    logic             wrap_d;
    logic             lockup_d;

    always_comb begin
        fill       = ^(state & TAPS);
        next_state = {fill, state[WIDTH-1:1]};
        step_rise  = step & ~step_q;
        adv        = en & (step_mode ? step_rise : 1'b1);
        load_val   = (seed == '0) ? RESET_SEED : seed;
    end

    // Priority: load, then zero guard (independent of en), then advance.
    always_comb begin
        state_d  = state;
        start_d  = start;
        cnt_d    = cnt;
        wrap_d   = 1'b0;
        lockup_d = 1'b0;
        if (load) begin
            state_d = load_val;
            start_d = load_val;
            cnt_d   = '0;
        end else if (state == '0) begin
            state_d  = RESET_SEED;
            start_d  = RESET_SEED;
            cnt_d    = '0;
            lockup_d = 1'b1;
        end else if (adv) begin
            state_d = next_state;
            cnt_d   = cnt + 1'b1;
            wrap_d  = (next_state == start);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= RESET_SEED;
            start  <= RESET_SEED;
            cnt    <= '0;
            wrap   <= 1'b0;
            lockup <= 1'b0;
            step_q <= 1'b0;
        end else begin
            state  <= state_d;
            start  <= start_d;
            cnt    <= cnt_d;
            wrap   <= wrap_d;
            lockup <= lockup_d;
            step_q <= step;
        end
    end

    assign bit_out = state[0];

`ifdef LFSR_SEG_EN
    // Active-low segments a..g in [7:1], decimal point in [0] kept lit-low.
    function automatic logic [7:0] hex7(input logic [3:0] h);
        logic [7:0] s;
        case (h)
            4'h0: s = 8'b00000010;
            4'h1: s = 8'b10011110;
            4'h2: s = 8'b00100100;
            4'h3: s = 8'b00001100;
            4'h4: s = 8'b10011000;
            4'h5: s = 8'b01001000;
            4'h6: s = 8'b01000000;
            4'h7: s = 8'b00011110;
            4'h8: s = 8'b00000000;
            4'h9: s = 8'b00001000;
            4'hA: s = 8'b00010000;
            4'hB: s = 8'b11000000;
            4'hC: s = 8'b01100010;
            4'hD: s = 8'b10000100;
            4'hE: s = 8'b01100000;
            default: s = 8'b01110000;
        endcase
        return s;
    endfunction

    // Zero-extension makes bits beyond WIDTH read as 0 for narrow registers.
    localparam logic [31:0] SEED_EXT = 32'(RESET_SEED);

    logic [31:0] state_ext;
    logic [15:0] seg_d;

    always_comb begin
        state_ext = 32'(state);
        seg_d     = {hex7(state_ext[7:4]), hex7(state_ext[3:0])};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seg <= {hex7(SEED_EXT[7:4]), hex7(SEED_EXT[3:0])};
        end else begin
            seg <= seg_d;
        end
    end
`endif

endmodule

// File: tb/tb_lfsr_gen.sv
// Directed bench for lfsr_gen: default taps on one instance, non-invertible taps (8'h1C) on a second.
module tb_lfsr_gen;

    logic       clk = 1'b0;
    logic       rst;
    logic       en, load, step_mode, step;
    logic [7:0] seed;
    logic [7:0] state, cnt;
    logic       bit_out, wrap, lockup;

    logic       en2, load2;
    logic [7:0] seed2;
    logic [7:0] state2, cnt2;
    logic       bit_out2, wrap2, lockup2;
`ifdef LFSR_SEG_EN
    logic [15:0] seg, seg2;
`endif

    int unsigned total = 0;
    int unsigned bad   = 0;

    always #5 clk = ~clk;

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1D), .RESET_SEED(8'h01)) dut (
        .clk(clk), .rst(rst), .en(en), .load(load), .seed(seed),
        .step_mode(step_mode), .step(step),
        .state(state), .bit_out(bit_out), .cnt(cnt), .wrap(wrap), .lockup(lockup)
`ifdef LFSR_SEG_EN
        , .seg(seg)
`endif
    );

    lfsr_gen #(.WIDTH(8), .TAPS(8'h1C), .RESET_SEED(8'h01)) dut_nz (
        .clk(clk), .rst(rst), .en(en2), .load(load2), .seed(seed2),
        .step_mode(1'b0), .step(1'b0),
        .state(state2), .bit_out(bit_out2), .cnt(cnt2), .wrap(wrap2), .lockup(lockup2)
`ifdef LFSR_SEG_EN
        , .seg(seg2)
`endif
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] seq [5];
        logic       seen [256];
        int unsigned distinct;

        seq[0] = 8'h80; seq[1] = 8'h40; seq[2] = 8'h20; seq[3] = 8'h10; seq[4] = 8'h88;

        rst = 1'b1; en = 1'b0; load = 1'b0; seed = '0; step_mode = 1'b0; step = 1'b0;
        en2 = 1'b0; load2 = 1'b0; seed2 = '0;
        repeat (2) tick();

        check_val("rst_state",  32'(state),   32'h01);
        check_val("rst_cnt",    32'(cnt),     32'h00);
        check_val("rst_wrap",   32'(wrap),    32'h0);
        check_val("rst_lockup", 32'(lockup),  32'h0);
        check_val("rst_bitout", 32'(bit_out), 32'h1);
`ifdef LFSR_SEG_EN
        check_val("rst_seg",    32'(seg),     32'h029E);
`endif

        rst = 1'b0;
        en  = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            check_val("seq_state", 32'(state), 32'(seq[k]));
            check_val("seq_cnt",   32'(cnt),   32'(k + 1));
        end

        // Full period from 01
        rst = 1'b1; #1; rst = 1'b0;
        for (int i = 0; i < 256; i++) seen[i] = 1'b0;
        seen[1]  = 1'b1;
        distinct = 1;
        for (int a = 1; a <= 255; a++) begin
            tick();
            check_val("period_wrap", 32'(wrap), (a == 255) ? 32'h1 : 32'h0);
            if (a < 255 && state != 8'h00 && !seen[state]) begin
                seen[state] = 1'b1;
                distinct++;
            end
        end
        check_val("period_state",    32'(state), 32'h01);
        check_val("period_cnt",      32'(cnt),   32'hFF);
        check_val("period_distinct", distinct,   32'd255);

        // Asynchronous reset between edges, while wrap is high
        #2 rst = 1'b1;
        #1;
        check_val("arst_state", 32'(state), 32'h01);
        check_val("arst_cnt",   32'(cnt),   32'h00);
        check_val("arst_wrap",  32'(wrap),  32'h0);
`ifdef LFSR_SEG_EN
        tick();
        check_val("arst_seg", 32'(seg), 32'h029E);
`endif
        rst = 1'b0;

        repeat (3) tick();
        check_val("run_state", 32'(state), 32'h20);
        load = 1'b1; seed = 8'hA5;
        tick();
        check_val("load_state", 32'(state), 32'hA5);
        check_val("load_cnt",   32'(cnt),   32'h00);
        check_val("load_wrap",  32'(wrap),  32'h0);
        seed = 8'h00;
        tick();
        check_val("load0_state",  32'(state),  32'h01);
        check_val("load0_lockup", 32'(lockup), 32'h0);
        check_val("load0_cnt",    32'(cnt),    32'h00);

        load = 1'b0; step_mode = 1'b1; step = 1'b1;
        tick();
        check_val("step_first", 32'(state), 32'h80);
        for (int h = 0; h < 3; h++) begin
            tick();
            check_val("step_held", 32'(state), 32'h80);
        end
        step = 1'b0;
        tick();
        check_val("step_low", 32'(state), 32'h80);
        step = 1'b1;
        tick();
        check_val("step_second", 32'(state), 32'h40);
        check_val("step_cnt",    32'(cnt),   32'h02);
        step = 1'b0;

        // Non-invertible taps: 02 -> 01 -> 00 -> guard
        load2 = 1'b1; seed2 = 8'h02;
        tick();
        check_val("nz_load", 32'(state2), 32'h02);
        load2 = 1'b0; en2 = 1'b1;
        tick();
        check_val("nz_s1", 32'(state2), 32'h01);
        tick();
        check_val("nz_zero",      32'(state2),  32'h00);
        check_val("nz_zero_lock", 32'(lockup2), 32'h0);
        check_val("nz_zero_cnt",  32'(cnt2),    32'h02);
        en2 = 1'b0;
        tick();
        check_val("nz_guard_state", 32'(state2),  32'h01);
        check_val("nz_guard_lock",  32'(lockup2), 32'h1);
        check_val("nz_guard_cnt",   32'(cnt2),    32'h00);
        tick();
        check_val("nz_after_lock",  32'(lockup2), 32'h0);
        check_val("nz_after_state", 32'(state2),  32'h01);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
